// File: rtl/result_forward_stage_pkg.sv
// rtl/result_forward_stage_pkg.sv - shared widths and forwarding-select encodings
package result_forward_stage_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;
endpackage

// File: rtl/result_forward_stage_if.sv
// rtl/result_forward_stage_if.sv - execute-side, memory-side and hazard signals of the result forward stage
interface result_forward_stage_if;
    import result_forward_stage_pkg::*;

    logic [DATA_W-1:0] AluOutE;
    logic [DATA_W-1:0] writeDataE;
    logic [REG_AW-1:0] writeRegE;
    logic              regWriteE;
    logic              memToRegE;
    logic              memWriteE;
    logic [REG_AW-1:0] RsE;
    logic [REG_AW-1:0] RtE;
    logic [DATA_W-1:0] rfData1E;
    logic [DATA_W-1:0] rfData2E;
    logic [REG_AW-1:0] RsD;
    logic [REG_AW-1:0] RtD;
    logic [DATA_W-1:0] readDataM;

    logic [DATA_W-1:0] AluOutM;
    logic [DATA_W-1:0] writeDataM;
    logic              memWriteM;
    logic [DATA_W-1:0] value1;
    logic [DATA_W-1:0] value2;
    logic [DATA_W-1:0] resultW;
    logic [REG_AW-1:0] writeRegW;
    logic              regWriteW;
    logic              stallF;
    logic              stallD;
    logic              flushE;
    fwd_sel_t          fwd_sel1;
    fwd_sel_t          fwd_sel2;

    modport master (
        output AluOutE, writeDataE, writeRegE, regWriteE, memToRegE, memWriteE,
               RsE, RtE, rfData1E, rfData2E, RsD, RtD, readDataM,
        input  AluOutM, writeDataM, memWriteM, value1, value2, resultW,
               writeRegW, regWriteW, stallF, stallD, flushE, fwd_sel1, fwd_sel2
    );

    modport slave (
        input  AluOutE, writeDataE, writeRegE, regWriteE, memToRegE, memWriteE,
               RsE, RtE, rfData1E, rfData2E, RsD, RtD, readDataM,
        output AluOutM, writeDataM, memWriteM, value1, value2, resultW,
               writeRegW, regWriteW, stallF, stallD, flushE, fwd_sel1, fwd_sel2
    );
endinterface

// File: rtl/result_forward_stage_fwd_operand_mux.sv
// rtl/result_forward_stage_fwd_operand_mux.sv - selects one execute operand from M, W or the register file
module fwd_operand_mux
    import result_forward_stage_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              reg_write_m,
    input  logic              mem_to_reg_m,
    input  logic [REG_AW-1:0] write_reg_m,
    input  logic [DATA_W-1:0] alu_out_m,
    input  logic              reg_write_w,
    input  logic [REG_AW-1:0] write_reg_w,
    input  logic [DATA_W-1:0] result_w,
    input  logic [DATA_W-1:0] rf_data,
    output fwd_sel_t          sel,
    output logic [DATA_W-1:0] operand
);
    logic src_live;
    assign src_live = (src != '0);

    // A load sitting in M has no data yet; the stall logic keeps its consumer out of execute.
    always_comb begin
        sel     = FWD_RF;
        operand = rf_data;
        if (src_live && reg_write_m && !mem_to_reg_m && (write_reg_m == src)) begin
            sel     = FWD_M;
            operand = alu_out_m;
        end else if (src_live && reg_write_w && (write_reg_w == src)) begin
            sel     = FWD_W;
            operand = result_w;
        end
    end
endmodule

// File: rtl/result_forward_stage.sv
// rtl/result_forward_stage.sv - MEM/WB pipeline registers, operand forwarding and load-use hazard detection
module result_forward_stage
    import result_forward_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    result_forward_stage_if.slave bus
);
    logic [DATA_W-1:0] alu_out_m;
    logic [DATA_W-1:0] write_data_m;
    logic [REG_AW-1:0] write_reg_m;
    logic              reg_write_m;
    logic              mem_to_reg_m;
    logic              mem_write_m;

    logic [DATA_W-1:0] read_data_w;
    logic [DATA_W-1:0] alu_out_w;
    logic [REG_AW-1:0] write_reg_w;
    logic              reg_write_w;
    logic              mem_to_reg_w;

    logic [DATA_W-1:0] result_w;
    logic              lwstall;

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_m    <= '0;
            write_data_m <= '0;
            write_reg_m  <= '0;
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            mem_write_m  <= 1'b0;
            read_data_w  <= '0;
            alu_out_w    <= '0;
            write_reg_w  <= '0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
        end else begin
            alu_out_m    <= bus.AluOutE;
            write_data_m <= bus.writeDataE;
            write_reg_m  <= bus.writeRegE;
            reg_write_m  <= bus.regWriteE;
            mem_to_reg_m <= bus.memToRegE;
            mem_write_m  <= bus.memWriteE;
            read_data_w  <= bus.readDataM;
            alu_out_w    <= alu_out_m;
            write_reg_w  <= write_reg_m;
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
        end
    end

    assign result_w = mem_to_reg_w ? read_data_w : alu_out_w;

    fwd_operand_mux u_fwd_rs (
        .src          (bus.RsE),
        .reg_write_m  (reg_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .write_reg_m  (write_reg_m),
        .alu_out_m    (alu_out_m),
        .reg_write_w  (reg_write_w),
        .write_reg_w  (write_reg_w),
        .result_w     (result_w),
        .rf_data      (bus.rfData1E),
        .sel          (bus.fwd_sel1),
        .operand      (bus.value1)
    );

    fwd_operand_mux u_fwd_rt (
        .src          (bus.RtE),
        .reg_write_m  (reg_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .write_reg_m  (write_reg_m),
        .alu_out_m    (alu_out_m),
        .reg_write_w  (reg_write_w),
        .write_reg_w  (write_reg_w),
        .result_w     (result_w),
        .rf_data      (bus.rfData2E),
        .sel          (bus.fwd_sel2),
        .operand      (bus.value2)
    );

    // A load in E whose target is read in D must wait one cycle for the memory data.
    assign lwstall = bus.memToRegE && bus.regWriteE && (bus.writeRegE != '0) &&
                     ((bus.writeRegE == bus.RsD) || (bus.writeRegE == bus.RtD));

    assign bus.stallF     = lwstall;
    assign bus.stallD     = lwstall;
    assign bus.flushE     = lwstall;
    assign bus.AluOutM    = alu_out_m;
    assign bus.writeDataM = write_data_m;
    assign bus.memWriteM  = mem_write_m;
    assign bus.resultW    = result_w;
    assign bus.writeRegW  = write_reg_w;
    assign bus.regWriteW  = reg_write_w;
endmodule
